// File: rtl/fp_pkg.sv
// Shared single-precision floating-point constants and types used by the adder
// post-processing stages.
package fp_pkg;

    localparam int unsigned SIGN        = 31;
    localparam int unsigned EXPO        = 30;
    localparam int unsigned EXPO_LENGTH = 7;
    localparam int unsigned SIGNI       = 23;
    localparam int unsigned EXPO_MAX    = 255;

    typedef enum logic [2:0] {
        IDLE,
        NORM_R,
        NORM_L,
        ROUND,
        DONE
    } norm_state_t;

    // Magnitude fields (exponent + fraction) of the special encodings; prepend the sign.
    localparam logic [SIGN-1:0] ZERO_MAG = '0;
    localparam logic [SIGN-1:0] INF_MAG  = {8'hFF, 23'h000000};

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of a normalised significand from its guard/round/sticky bits.
module fp_round_rne #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0] sig,
    input  logic [2:0]   grs,
    output logic [W-1:0] rounded,
    output logic         carry
);

    logic inc;

    // Ties (G=1, R=S=0) only round up when that makes the LSB even.
    assign inc = grs[2] & (grs[1] | grs[0] | sig[0]);
    assign {carry, rounded} = {1'b0, sig} + {{W{1'b0}}, inc};

endmodule

// File: rtl/fp_add_normalizer.sv
// Normalise-and-round stage behind the FP adder: one shift per clock, valid/ready
// handshake on input and output, result held until the consumer takes it.
module fp_add_normalizer #(
    parameter int unsigned SIGNI       = fp_pkg::SIGNI,
    parameter int unsigned EXPO_LENGTH = fp_pkg::EXPO_LENGTH,
    parameter int unsigned EXPO_MAX    = fp_pkg::EXPO_MAX
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sign,
    input  logic [EXPO_LENGTH:0]         in_expo,
    input  logic [SIGNI+1:0]             in_signi,
    input  logic [2:0]                   in_grs,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SIGNI+EXPO_LENGTH+1:0] out,
    output logic                         under_overflow
);

    import fp_pkg::*;

    localparam int unsigned EW = EXPO_LENGTH + 1;
    localparam logic [EW:0] EXPO_TOP = (EW+1)'(EXPO_MAX);
    localparam logic [EW:0] EXPO_ONE = (EW+1)'(1);

    norm_state_t state, state_n;

    logic                         sign_r, sign_n;
    logic [EW:0]                  expo_r, expo_n;
    logic [SIGNI+1:0]             signi_r, signi_n;
    logic                         g_r, r_r, s_r;
    logic                         g_n, r_n, s_n;
    logic [SIGNI+EXPO_LENGTH+1:0] out_r, out_n;
    logic                         flag_r, flag_n;

    logic [EW:0]    expo_inc;
    logic [SIGNI:0] rnd_sig;
    logic           rnd_carry;
    logic [SIGNI:0] carry_shift;

    fp_round_rne #(
        .W (SIGNI + 1)
    ) u_round (
        .sig     (signi_r[SIGNI:0]),
        .grs     ({g_r, r_r, s_r}),
        .rounded (rnd_sig),
        .carry   (rnd_carry)
    );

    assign expo_inc    = expo_r + EXPO_ONE;
    assign carry_shift = {rnd_carry, rnd_sig[SIGNI:1]};

    assign in_ready       = (state == IDLE);
    assign out_valid      = (state == DONE);
    assign out            = out_r;
    assign under_overflow = flag_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sign_r  <= 1'b0;
            expo_r  <= '0;
            signi_r <= '0;
            g_r     <= 1'b0;
            r_r     <= 1'b0;
            s_r     <= 1'b0;
            out_r   <= '0;
            flag_r  <= 1'b0;
        end else begin
            state   <= state_n;
            sign_r  <= sign_n;
            expo_r  <= expo_n;
            signi_r <= signi_n;
            g_r     <= g_n;
            r_r     <= r_n;
            s_r     <= s_n;
            out_r   <= out_n;
            flag_r  <= flag_n;
        end
    end

    always_comb begin
        state_n = state;
        sign_n  = sign_r;
        expo_n  = expo_r;
        signi_n = signi_r;
        g_n     = g_r;
        r_n     = r_r;
        s_n     = s_r;
        out_n   = out_r;
        flag_n  = flag_r;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_n          = in_sign;
                    expo_n          = {1'b0, in_expo};
                    signi_n         = in_signi;
                    {g_n, r_n, s_n} = in_grs;
                    // Special operands resolve immediately; the priority order matters.
                    if (in_expo == EXPO_TOP[EW-1:0]) begin
                        out_n   = {in_sign, INF_MAG};
                        flag_n  = 1'b1;
                        state_n = DONE;
                    end else if (in_signi == '0 && in_grs == '0) begin
                        out_n   = {in_sign, ZERO_MAG};
                        flag_n  = 1'b0;
                        state_n = DONE;
                    end else if (in_expo == '0) begin
                        out_n   = {in_sign, ZERO_MAG};
                        flag_n  = 1'b1;
                        state_n = DONE;
                    end else if (in_signi[SIGNI+1]) begin
                        state_n = NORM_R;
                    end else if (in_signi[SIGNI]) begin
                        state_n = ROUND;
                    end else begin
                        state_n = NORM_L;
                    end
                end
            end

            NORM_R: begin
                signi_n = signi_r >> 1;
                g_n     = signi_r[0];
                r_n     = g_r;
                s_n     = r_r | s_r;
                expo_n  = expo_inc;
                if (expo_inc == EXPO_TOP) begin
                    out_n   = {sign_r, INF_MAG};
                    flag_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    state_n = ROUND;
                end
            end

            NORM_L: begin
                if (expo_r == EXPO_ONE) begin
                    out_n   = {sign_r, ZERO_MAG};
                    flag_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    signi_n = {signi_r[SIGNI:0], g_r};
                    g_n     = r_r;
                    r_n     = 1'b0;
                    expo_n  = expo_r - EXPO_ONE;
                    // Bit SIGNI-1 becomes the hidden bit after this shift.
                    if (signi_r[SIGNI-1]) begin
                        state_n = ROUND;
                    end
                end
            end

            ROUND: begin
                state_n = DONE;
                flag_n  = 1'b0;
                if (rnd_carry) begin
                    signi_n = {1'b0, carry_shift};
                    expo_n  = expo_inc;
                    if (expo_inc == EXPO_TOP) begin
                        out_n  = {sign_r, INF_MAG};
                        flag_n = 1'b1;
                    end else begin
                        out_n = {sign_r, expo_inc[EW-1:0], carry_shift[SIGNI-1:0]};
                    end
                end else begin
                    signi_n = {1'b0, rnd_sig};
                    out_n   = {sign_r, expo_r[EW-1:0], rnd_sig[SIGNI-1:0]};
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Directed bench for fp_add_normalizer: hand-computed results, latencies,
// backpressure and mid-operation reset.
module tb_fp_add_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_expo;
    logic [24:0] in_signi;
    logic [2:0]  in_grs;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        under_overflow;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    fp_add_normalizer #(
        .SIGNI       (23),
        .EXPO_LENGTH (7),
        .EXPO_MAX    (255)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_expo        (in_expo),
        .in_signi       (in_signi),
        .in_grs         (in_grs),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out            (out),
        .under_overflow (under_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one operand and return #1 after its accept edge.
    task automatic send(input string tag, input logic s, input logic [7:0] e,
                        input logic [24:0] m, input logic [2:0] grs);
        check({tag, " in_ready before send"}, {31'b0, in_ready}, 32'd1);
        in_sign  = s;
        in_expo  = e;
        in_signi = m;
        in_grs   = grs;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; counts edges until out_valid rises.
    task automatic collect(input string tag, input logic [31:0] exp_out, input logic exp_flag,
                           input int unsigned exp_lat, input logic pop);
        int unsigned lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " out"}, out, exp_out);
        check({tag, " flag"}, {31'b0, under_overflow}, {31'b0, exp_flag});
        if (pop) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({tag, " out_valid after pop"}, {31'b0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        logic saw_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_expo   = '0;
        in_signi  = '0;
        in_grs    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out", out, 32'h0);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset flag", {31'b0, under_overflow}, 32'd0);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send("carry", 1'b0, 8'd127, 25'h1000000, 3'b000);
        collect("carry", 32'h40000000, 1'b0, 3, 1'b1);
        send("norm", 1'b0, 8'd127, 25'h0C00000, 3'b000);
        collect("norm", 32'h3FC00000, 1'b0, 2, 1'b1);
        send("tie_even", 1'b0, 8'd127, 25'h0800000, 3'b100);
        collect("tie_even", 32'h3F800000, 1'b0, 2, 1'b1);
        send("tie_odd", 1'b0, 8'd127, 25'h0800001, 3'b100);
        collect("tie_odd", 32'h3F800002, 1'b0, 2, 1'b1);
        send("above_half", 1'b0, 8'd127, 25'h0800000, 3'b110);
        collect("above_half", 32'h3F800001, 1'b0, 2, 1'b1);
        send("lshift2", 1'b0, 8'd127, 25'h0200000, 3'b000);
        collect("lshift2", 32'h3E800000, 1'b0, 4, 1'b1);
        send("lshift_g", 1'b0, 8'd127, 25'h0400000, 3'b100);
        collect("lshift_g", 32'h3F000001, 1'b0, 3, 1'b1);
        send("rnd_carry", 1'b0, 8'd127, 25'h0FFFFFF, 3'b100);
        collect("rnd_carry", 32'h40000000, 1'b0, 2, 1'b1);
        send("rshift_rnd", 1'b0, 8'd127, 25'h1000003, 3'b000);
        collect("rshift_rnd", 32'h40000002, 1'b0, 3, 1'b1);
        send("neg", 1'b1, 8'd127, 25'h0C00000, 3'b000);
        collect("neg", 32'hBFC00000, 1'b0, 2, 1'b1);
        send("overflow", 1'b0, 8'd254, 25'h1000000, 3'b000);
        collect("overflow", 32'h7F800000, 1'b1, 2, 1'b1);
        send("rnd_overflow", 1'b1, 8'd254, 25'h0FFFFFF, 3'b111);
        collect("rnd_overflow", 32'hFF800000, 1'b1, 2, 1'b1);
        send("underflow", 1'b0, 8'd1, 25'h0400000, 3'b000);
        collect("underflow", 32'h00000000, 1'b1, 2, 1'b1);
        send("inf_in", 1'b1, 8'd255, 25'h0C00000, 3'b000);
        collect("inf_in", 32'hFF800000, 1'b1, 1, 1'b1);
        send("zero_in", 1'b1, 8'd100, 25'h0000000, 3'b000);
        collect("zero_in", 32'h80000000, 1'b0, 1, 1'b1);
        send("expo0", 1'b0, 8'd0, 25'h0800000, 3'b000);
        collect("expo0", 32'h00000000, 1'b1, 1, 1'b1);

        // Backpressure with a second operand already waiting.
        send("bp_a", 1'b0, 8'd127, 25'h0C00000, 3'b000);
        collect("bp_a", 32'h3FC00000, 1'b0, 2, 1'b0);
        in_sign  = 1'b0;
        in_expo  = 8'd127;
        in_signi = 25'h1000000;
        in_grs   = 3'b000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp hold out_valid", {31'b0, out_valid}, 32'd1);
            check("bp hold out", out, 32'h3FC00000);
            check("bp hold in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp release out_valid", {31'b0, out_valid}, 32'd0);
        check("bp release in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_b accepted", {31'b0, in_ready}, 32'd0);
        collect("bp_b", 32'h40000000, 1'b0, 3, 1'b1);
        send("b2b", 1'b0, 8'd127, 25'h0200000, 3'b000);
        collect("b2b", 32'h3E800000, 1'b0, 4, 1'b1);

        // Reset in the third NORM_L cycle of a long left shift.
        send("rst_op", 1'b0, 8'd127, 25'h0010000, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        check("pre-reset busy", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid reset out_valid", {31'b0, out_valid}, 32'd0);
        check("mid reset in_ready", {31'b0, in_ready}, 32'd1);
        check("mid reset out", out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post reset out_valid", {31'b0, out_valid}, 32'd0);
        check("post reset in_ready", {31'b0, in_ready}, 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("no stale result", {31'b0, saw_valid}, 32'd0);
        send("recover", 1'b0, 8'd127, 25'h0C00000, 3'b000);
        collect("recover", 32'h3FC00000, 1'b0, 2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
